// File: rtl/key_evt_pkg.sv
// ---------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key event path. It holds the event word layout,
// the field offsets and the state encoding of the auto-repeat FSM, plus a
// helper that packs an event word.
// ---------------------------------------------------------------------------
package key_evt_pkg;

  localparam int EVT_W      = 11;
  localparam int REPEAT_BIT = 10;
  localparam int MAKE_BIT   = 9;
  localparam int CODE_MSB   = 8;
  localparam int CODE_LSB   = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  function automatic logic [EVT_W-1:0] pack_evt(input logic       rpt,
                                                input logic       mk,
                                                input logic [8:0] code);
    logic [EVT_W-1:0] v;
    v                     = '0;
    v[REPEAT_BIT]         = rpt;
    v[MAKE_BIT]           = mk;
    v[CODE_MSB:CODE_LSB]  = code;
    return v;
  endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// ---------------------------------------------------------------------------
// key_event_scheduler_if
// Bundles the decoder-side inputs and the event stream handshake of the
// key event scheduler.
//   key_valid   : one-cycle pulse from the PS/2 decoder
//   last_change : {extend, code} of the key that changed
//   key_down    : held-key bitmap, already updated in the key_valid cycle
//   evt_ready   : consumer accepts the head event
//   evt_valid   : head event available
//   evt_code    : head event key code
//   evt_make    : 1 = press, 0 = release
//   evt_repeat  : 1 = auto-repeat event
// slave  : the scheduler side
// master : the environment (decoder + consumer) side
// ---------------------------------------------------------------------------
interface key_event_scheduler_if;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         evt_ready;
  logic         evt_valid;
  logic [8:0]   evt_code;
  logic         evt_make;
  logic         evt_repeat;

  modport slave (
    input  key_valid, last_change, key_down, evt_ready,
    output evt_valid, evt_code, evt_make, evt_repeat
  );

  modport master (
    output key_valid, last_change, key_down, evt_ready,
    input  evt_valid, evt_code, evt_make, evt_repeat
  );
endinterface

// File: rtl/key_evt_fifo.sv
// ---------------------------------------------------------------------------
// key_evt_fifo
// Synchronous show-ahead FIFO. The head entry is always visible on o_data
// while the FIFO is not empty. A pop on an empty FIFO is ignored. A push
// into a full FIFO is accepted only when a pop happens in the same cycle.
//   clk, rst : clock, asynchronous active-high reset
//   i_push   : write i_data
//   i_pop    : consume the head entry
//   o_data   : head entry (show-ahead)
//   o_count  : occupancy, 0..DEPTH
//   o_full   : count == DEPTH
//   o_empty  : count == 0
// ---------------------------------------------------------------------------
module key_evt_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// ---------------------------------------------------------------------------
// key_event_scheduler
// Turns decoder key_valid pulses into a buffered, flow-controlled event
// stream and schedules typematic auto-repeat events for the most recently
// pressed key while it stays held.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : decoder inputs and event stream handshake (slave side)
//   repeat_en   : 1 = generate auto-repeat events
//   clr_ovf     : clears ovf
//   fifo_count  : event buffer occupancy
//   ovf         : sticky, an event was dropped on a full buffer
//
// Repeat FSM
//   state  | meaning
//   IDLE   | no key is being repeated, timer parked at 0
//   DELAY  | key held, counting down to the first repeat
//   REPEAT | key held, counting down between repeats
// ---------------------------------------------------------------------------
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 27
) (
  input  logic                          clk,
  input  logic                          rst,
  key_event_scheduler_if.slave          bus,
  input  logic                          repeat_en,
  input  logic                          clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf
);
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [8:0]       r_rep_code;
  logic [8:0]       w_rep_code_nxt;
  logic             r_ovf;

  logic             w_make;
  logic             w_rep_held;
  logic             w_active;
  logic             w_push;
  logic [EVT_W-1:0] w_push_data;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [EVT_W-1:0] w_head;

  // key_down already reflects the change in the key_valid cycle.
  assign w_make     = bus.key_down[bus.last_change];
  assign w_rep_held = bus.key_down[r_rep_code];
  assign w_active   = (r_state == ST_DELAY) || (r_state == ST_REPEAT);

  // Decoder events take priority over a coinciding repeat expiry, so at most
  // one push happens per cycle. The timer still advances on such a cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_rep_code_nxt = r_rep_code;
    w_push         = 1'b0;
    w_push_data    = '0;
    if (bus.key_valid) begin
      w_push      = 1'b1;
      w_push_data = pack_evt(1'b0, w_make, bus.last_change);
      if (w_make && repeat_en) begin
        w_state_nxt    = ST_DELAY;
        w_timer_nxt    = DELAY_LOAD;
        w_rep_code_nxt = bus.last_change;
      end else if (w_active) begin
        if ((!w_make && (bus.last_change == r_rep_code)) || !w_rep_held || !repeat_en) begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_REPEAT;
          w_timer_nxt = PERIOD_LOAD;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end else if (r_state != ST_IDLE) begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    end else if (w_active) begin
      // A missing key_down bit also covers a break the decoder never reported.
      if (!w_rep_held || !repeat_en) begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end else if (r_timer == '0) begin
        w_push      = 1'b1;
        w_push_data = pack_evt(1'b1, 1'b1, r_rep_code);
        w_state_nxt = ST_REPEAT;
        w_timer_nxt = PERIOD_LOAD;
      end else begin
        w_timer_nxt = r_timer - CNT_W'(1);
      end
    end else if (r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_rep_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_rep_code <= w_rep_code_nxt;
    end
  end

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop  = bus.evt_ready && !w_empty;
  // A same-cycle pop frees a slot, so only a push without a pop is lost.
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;

  // Fields read as zero while the buffer is empty so reset values are clean.
  assign bus.evt_valid  = !w_empty;
  assign bus.evt_code   = w_empty ? 9'h000 : w_head[CODE_MSB:CODE_LSB];
  assign bus.evt_make   = !w_empty && w_head[MAKE_BIT];
  assign bus.evt_repeat = !w_empty && w_head[REPEAT_BIT];

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits directly after the PS/2 keyboard decoder. Turns its one-cycle key_valid pulses into a buffered, flow-controlled event stream.
- Each event carries scan code, make/break and a repeat flag.
- Also schedules typematic auto-repeat events for the most recently pressed key while it stays held.
- Downstream consumers (game FSMs, text entry) pop events with a valid/ready handshake and never miss a keystroke.

Parameters:
- FIFO_DEPTH, 8, event buffer entries; power of two, at least 2.
- REPEAT_DELAY, 50000000, cycles from make to first repeat (0.5 s at 100 MHz); at least 2.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeats; at least 2.
- CNT_W, 27, timer width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- key_valid  in  1  one-cycle pulse from decoder; key_down already reflects the change in this cycle
- last_change  in  9  {extend, code}, the key that changed
- key_down  in  512  held-key bitmap from decoder
- repeat_en  in  1  1 = generate auto-repeat events
- evt_ready  in  1  consumer accepts the event at the head
- clr_ovf  in  1  clears ovf
- evt_valid  out  1  head event available
- evt_code  out  9  head event key code
- evt_make  out  1  1 = press, 0 = release
- evt_repeat  out  1  1 = auto-repeat event (evt_make is always 1 when set)
- fifo_count  out  4  occupancy, 0..FIFO_DEPTH (width = clog2(FIFO_DEPTH)+1)
- ovf  out  1  sticky: an event was dropped

Behaviour:
- Reset (asynchronous, any time, including mid-repeat or mid-handshake): FIFO empty, evt_valid=0, evt_code=0, evt_make=0, evt_repeat=0, fifo_count=0, ovf=0, FSM=IDLE, timer=0.
- Event format: {repeat, make, code[8:0]}, 11 bits.
- Decoder event: when key_valid=1, make = key_down[last_change]. Push {0, make, last_change}.
- Latency: push at edge N. evt_valid and evt_* are valid after edge N when the FIFO was empty (show-ahead head).
- Pop: occurs when evt_valid && evt_ready at a clock edge; the next entry is presented after that edge. evt_* are stable while evt_valid=1 and evt_ready=0. evt_ready with the FIFO empty is ignored.
- Full FIFO, push without a same-cycle pop: push is dropped and ovf is set to 1. ovf holds until clr_ovf=1. If clr_ovf and a new drop occur in the same cycle, ovf stays 1.
- Full FIFO, push with a same-cycle pop: both are performed; count is unchanged; no overflow.
- Empty FIFO, push with a same-cycle pop: no pop, because evt_valid=0.
- Pointers wrap modulo FIFO_DEPTH. fifo_count = pushes minus pops.
- Repeat FSM: rep_code register plus a down-counter timer.
  - IDLE: on key_valid with make=1 and repeat_en=1, load rep_code=last_change and timer=REPEAT_DELAY-1, then go to DELAY.
  - DELAY: decrement timer. At timer==0, push {1, 1, rep_code}, load timer=REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: decrement timer. At timer==0, push a repeat event and reload REPEAT_PERIOD-1.
  - From DELAY or REPEAT:
    - key_valid with make=1 restarts DELAY with the new code.
    - key_valid with make=0 and last_change==rep_code returns to IDLE.
    - A break of another key leaves repeat running.
    - key_down[rep_code]==0 returns to IDLE; this covers missed breaks.
    - repeat_en=0 returns to IDLE.
- Simultaneous key_valid and repeat expiry: only the decoder event is pushed, and the FSM follows the key_valid rule. At most one push per cycle.
- Repeat pushes that hit a full FIFO are dropped and set ovf like any other push. The timer keeps running regardless of FIFO state.

Decomposition:
- Package key_evt_pkg holds:
  - the event width constant (11);
  - the field offsets (REPEAT bit 10, MAKE bit 9, CODE 8:0);
  - the repeat FSM state encoding: IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2.
- One sub-module, key_evt_fifo: synchronous show-ahead FIFO with parameterised width and depth, count output, and full/empty flags. It is shared with other event paths in the design.

Test Plan (bench parameters: FIFO_DEPTH=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, repeat_en=1 unless stated):
- Make then break: pulse key_valid with last_change=9'h01C and key_down[0x1C]=1; evt_ready=1 held. Then break. -> Event {0,1,0x01C} presented the cycle after the pulse, then {0,0,0x01C}; fifo_count returns to 0; ovf=0.
- Hold key 0x11D (extended) for 35 cycles after make. -> Make event, repeat event {1,1,0x11D} 20 cycles after make, then every 5 cycles (cycles 25, 30, 35); no repeat after break.
- Overflow: evt_ready=0, five make events. -> fifo_count=4, ovf=1, the fifth event is lost. Then one pop plus a push in the same cycle -> count stays 4 and ovf stays 1. clr_ovf -> ovf=0.
- Collision: key_valid (make 0x023) lands on the same cycle as a repeat expiry for 0x01C. -> Only {0,1,0x023} is pushed; the next repeat is for 0x023, 20 cycles later.
- Reset mid-operation: assert rst asynchronously in REPEAT with 3 entries queued. -> Outputs immediately at reset values and FSM IDLE; after release, no stale events.
- repeat_en=0 with a held key for 40 cycles. -> Only the make event is produced.
